// File: rtl/gmii_tx_arbiter_if.sv
// rtl/gmii_tx_arbiter_if.sv - frame source handshake bundle for both requesters of gmii_tx_arbiter
interface gmii_tx_arbiter_if;
  logic       req0;
  logic       req1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       valid0;
  logic       valid1;
  logic       last0;
  logic       last1;
  logic       rd0;
  logic       rd1;
  logic       gnt0;
  logic       gnt1;

  modport master (
    output req0, req1, data0, data1, valid0, valid1, last0, last1,
    input  rd0, rd1, gnt0, gnt1
  );

  modport slave (
    input  req0, req1, data0, data1, valid0, valid1, last0, last1,
    output rd0, rd1, gnt0, gnt1
  );
endinterface

// File: rtl/gmii_tx_arbiter.sv
// rtl/gmii_tx_arbiter.sv - round-robin two-source GMII transmit scheduler with preamble, SFD, underrun abort and IPG
module gmii_tx_arbiter #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IPG_BYTES      = 12
) (
  input  logic               Clk,
  input  logic               mr_main_reset_n,
  input  logic               enable,
  gmii_tx_arbiter_if.slave   src,
  output logic [7:0]         TXD,
  output logic               TX_EN,
  output logic               TX_ER,
  output logic               busy,
  output logic [7:0]         underrun_cnt
);

  localparam int MAX_CNT = (PREAMBLE_BYTES > IPG_BYTES) ? PREAMBLE_BYTES : IPG_BYTES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PREAMBLE_BYTES - 1);
  localparam logic [CNT_W-1:0] IPG_LOAD = CNT_W'(IPG_BYTES - 1);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, IPG} state_t;

  state_t           state_q, state_n;
  logic [7:0]       txd_q, txd_n;
  logic             tx_en_q, tx_en_n;
  logic             tx_er_q, tx_er_n;
  logic [1:0]       gnt_q, gnt_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             last_seen_q, last_seen_n;
  logic             rr_q, rr_n;
  logic [7:0]       ucnt_q, ucnt_n;

  logic       rd_now;
  logic       sel;
  logic [7:0] data_sel;
  logic       valid_sel;
  logic       last_sel;
  logic       grant_ok;
  logic       pick;
  logic       start;

  // The owning port keeps pulling until its last byte has been captured.
  assign rd_now    = (state_q == SFD) || ((state_q == DATA) && !last_seen_q);
  assign sel       = gnt_q[1];
  assign data_sel  = sel ? src.data1  : src.data0;
  assign valid_sel = sel ? src.valid1 : src.valid0;
  assign last_sel  = sel ? src.last1  : src.last0;

  // rr_q names the port that wins when both request.
  assign grant_ok = enable && (src.req0 || src.req1);
  assign pick     = (src.req0 && src.req1) ? rr_q : src.req1;

  assign src.rd0      = rd_now && gnt_q[0];
  assign src.rd1      = rd_now && gnt_q[1];
  assign src.gnt0     = gnt_q[0];
  assign src.gnt1     = gnt_q[1];
  assign TXD          = txd_q;
  assign TX_EN        = tx_en_q;
  assign TX_ER        = tx_er_q;
  assign busy         = (state_q != IDLE);
  assign underrun_cnt = ucnt_q;

  always_ff @(posedge Clk or negedge mr_main_reset_n) begin
    if (!mr_main_reset_n) begin
      state_q     <= IDLE;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      gnt_q       <= 2'b00;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
      rr_q        <= 1'b0;
      ucnt_q      <= 8'h00;
    end else begin
      state_q     <= state_n;
      txd_q       <= txd_n;
      tx_en_q     <= tx_en_n;
      tx_er_q     <= tx_er_n;
      gnt_q       <= gnt_n;
      cnt_q       <= cnt_n;
      last_seen_q <= last_seen_n;
      rr_q        <= rr_n;
      ucnt_q      <= ucnt_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    txd_n       = txd_q;
    tx_en_n     = tx_en_q;
    tx_er_n     = tx_er_q;
    gnt_n       = gnt_q;
    cnt_n       = cnt_q;
    last_seen_n = last_seen_q;
    rr_n        = rr_q;
    ucnt_n      = ucnt_q;
    start       = 1'b0;

    case (state_q)
      IDLE: begin
        start = grant_ok;
      end
      PRE: begin
        if (cnt_q == '0) begin
          state_n = SFD;
          txd_n   = 8'hD5;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      SFD, DATA: begin
        if (rd_now) begin
          state_n = DATA;
          if (valid_sel) begin
            txd_n       = data_sel;
            tx_er_n     = 1'b0;
            last_seen_n = last_sel;
          end else begin
            // Underrun: one errored byte, then treat the frame as finished.
            txd_n       = 8'h00;
            tx_er_n     = 1'b1;
            last_seen_n = 1'b1;
            if (ucnt_q != 8'hFF) begin
              ucnt_n = ucnt_q + 8'd1;
            end
          end
        end else begin
          state_n = IPG;
          txd_n   = 8'h00;
          tx_en_n = 1'b0;
          tx_er_n = 1'b0;
          gnt_n   = 2'b00;
          cnt_n   = IPG_LOAD;
        end
      end
      IPG: begin
        if (cnt_q == '0) begin
          state_n = IDLE;
          start   = grant_ok;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (start) begin
      state_n     = PRE;
      txd_n       = 8'h55;
      tx_en_n     = 1'b1;
      tx_er_n     = 1'b0;
      gnt_n       = pick ? 2'b10 : 2'b01;
      rr_n        = ~pick;
      cnt_n       = PRE_LOAD;
      last_seen_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// tb/tb_gmii_tx_arbiter.sv - directed bench for gmii_tx_arbiter (default and minimal-gap instances)
module tb_gmii_tx_arbiter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst_a_n, rst_b_n, enable, dut_sel;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       valid0, valid1, last0, last1;

  int vectors = 0;
  int miscompares = 0;
  int p_len = 7;
  int i_len = 12;

  logic [7:0] frame0 [16];
  logic [7:0] frame1 [16];
  int len0 = 0, len1 = 0, ur0 = -1, ur1 = -1, idx0 = 0, idx1 = 0;
  bit pend0 = 1'b0, pend1 = 1'b0;

  gmii_tx_arbiter_if ifa ();
  gmii_tx_arbiter_if ifb ();

  assign ifa.req0 = req0;     assign ifb.req0 = req0;
  assign ifa.req1 = req1;     assign ifb.req1 = req1;
  assign ifa.data0 = data0;   assign ifb.data0 = data0;
  assign ifa.data1 = data1;   assign ifb.data1 = data1;
  assign ifa.valid0 = valid0; assign ifb.valid0 = valid0;
  assign ifa.valid1 = valid1; assign ifb.valid1 = valid1;
  assign ifa.last0 = last0;   assign ifb.last0 = last0;
  assign ifa.last1 = last1;   assign ifb.last1 = last1;

  logic [7:0] txd_a, txd_b, ucnt_a, ucnt_b;
  logic       tx_en_a, tx_en_b, tx_er_a, tx_er_b, busy_a, busy_b;

  gmii_tx_arbiter #(.PREAMBLE_BYTES(7), .IPG_BYTES(12)) dut_a (
    .Clk(Clk), .mr_main_reset_n(rst_a_n), .enable(enable), .src(ifa.slave),
    .TXD(txd_a), .TX_EN(tx_en_a), .TX_ER(tx_er_a), .busy(busy_a), .underrun_cnt(ucnt_a)
  );

  gmii_tx_arbiter #(.PREAMBLE_BYTES(1), .IPG_BYTES(1)) dut_b (
    .Clk(Clk), .mr_main_reset_n(rst_b_n), .enable(enable), .src(ifb.slave),
    .TXD(txd_b), .TX_EN(tx_en_b), .TX_ER(tx_er_b), .busy(busy_b), .underrun_cnt(ucnt_b)
  );

  wire [7:0] txd   = dut_sel ? txd_b   : txd_a;
  wire       tx_en = dut_sel ? tx_en_b : tx_en_a;
  wire       tx_er = dut_sel ? tx_er_b : tx_er_a;
  wire       busy  = dut_sel ? busy_b  : busy_a;
  wire [7:0] ucnt  = dut_sel ? ucnt_b  : ucnt_a;
  wire       gnt0  = dut_sel ? ifb.gnt0 : ifa.gnt0;
  wire       gnt1  = dut_sel ? ifb.gnt1 : ifa.gnt1;
  wire       rd0   = dut_sel ? ifb.rd0  : ifa.rd0;
  wire       rd1   = dut_sel ? ifb.rd1  : ifa.rd1;
  wire [13:0] obs_v = {tx_en, tx_er, txd, gnt1, gnt0, rd1, rd0};

  // Frame sources: advance one byte after each edge on which rd was high.
  always @(negedge Clk) begin
    if (!gnt0) begin idx0 = 0; pend0 = 1'b0; end
    else begin if (pend0) idx0++; pend0 = rd0; end
    if (!gnt1) begin idx1 = 0; pend1 = 1'b0; end
    else begin if (pend1) idx1++; pend1 = rd1; end
    data0  = frame0[idx0[3:0]];
    valid0 = (idx0 < len0) && (idx0 != ur0);
    last0  = (idx0 == len0 - 1);
    data1  = frame1[idx1[3:0]];
    valid1 = (idx1 < len1) && (idx1 != ur1);
    last1  = (idx1 == len1 - 1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input int port, input logic [31:0] bytes, input int len);
    for (int k = 0; k < 4; k++) begin
      if (port == 1) frame1[k] = bytes[31 - 8*k -: 8];
      else           frame0[k] = bytes[31 - 8*k -: 8];
    end
    if (port == 1) len1 = len; else len0 = len;
  endtask

  // Entered at the falling edge of the first preamble cycle; returns at the one after the gap.
  task automatic check_frame(input int port, input int n, input int ur);
    logic [1:0] g;
    logic [7:0] b;
    g = (port == 1) ? 2'b10 : 2'b01;
    for (int i = 0; i < p_len; i++) begin
      chk("pre", obs_v, {2'b10, 8'h55, g, 2'b00});
      @(negedge Clk);
    end
    chk("sfd", obs_v, {2'b10, 8'hD5, g, g});
    @(negedge Clk);
    for (int k = 0; k < n; k++) begin
      if (k == ur) begin
        chk("underrun", obs_v, {2'b11, 8'h00, g, 2'b00});
        @(negedge Clk);
        break;
      end
      b = (port == 1) ? frame1[k] : frame0[k];
      chk("data", obs_v, {2'b10, b, g, (k < n - 1) ? g : 2'b00});
      @(negedge Clk);
    end
    for (int j = 0; j < i_len; j++) begin
      chk("ipg", obs_v, 14'd0);
      @(negedge Clk);
    end
  endtask

  initial begin
    dut_sel = 1'b0; rst_a_n = 1'b0; rst_b_n = 1'b0; enable = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_out", obs_v, 14'd0);
    chk("rst_busy", busy, 0);
    chk("rst_ucnt", ucnt, 0);
    rst_a_n = 1'b1;
    @(negedge Clk);

    // Single 4-byte frame from port 0
    load_frame(0, 32'h11223344, 4);
    req0 = 1'b1;
    @(negedge Clk);
    req0 = 1'b0;
    check_frame(0, 4, -1);
    chk("t1_idle", busy, 0);

    // Both requesting: grants alternate starting with port 0
    rst_a_n = 1'b0; @(negedge Clk); rst_a_n = 1'b1; @(negedge Clk);
    load_frame(0, 32'hA0A10000, 2);
    load_frame(1, 32'hB0B10000, 2);
    req0 = 1'b1; req1 = 1'b1;
    @(negedge Clk);
    check_frame(0, 2, -1);
    check_frame(1, 2, -1);
    check_frame(0, 2, -1);
    req0 = 1'b0; req1 = 1'b0;
    check_frame(1, 2, -1);
    chk("t2_idle", busy, 0);

    // Underrun on the third pull of a port-1 frame
    load_frame(1, 32'hC0C1C2C3, 4);
    ur1 = 2;
    req1 = 1'b1;
    @(negedge Clk);
    req1 = 1'b0;
    check_frame(1, 4, 2);
    chk("ucnt_1", ucnt, 1);

    // Underrun counter saturation
    ur1 = 0;
    req1 = 1'b1;
    @(negedge Clk);
    for (int i = 0; i < 254; i++) begin
      if (i == 253) req1 = 1'b0;
      check_frame(1, 4, 0);
    end
    chk("ucnt_255", ucnt, 255);
    req1 = 1'b1;
    @(negedge Clk);
    req1 = 1'b0;
    check_frame(1, 4, 0);
    chk("ucnt_sat", ucnt, 255);
    ur1 = -1;

    // enable low mid-frame: frame completes, no new grant until enable returns
    load_frame(0, 32'hE0E10000, 2);
    req0 = 1'b1;
    @(negedge Clk);
    enable = 1'b0;
    check_frame(0, 2, -1);
    chk("en_hold0", {tx_en, gnt1, gnt0, busy}, 0);
    repeat (3) @(negedge Clk);
    chk("en_hold3", {tx_en, gnt1, gnt0, busy}, 0);
    enable = 1'b1;
    @(negedge Clk);
    req0 = 1'b0;
    check_frame(0, 2, -1);

    // Asynchronous reset during DATA
    load_frame(1, 32'hF0F1F2F3, 4);
    req1 = 1'b1;
    @(negedge Clk);
    req1 = 1'b0;
    repeat (8) @(negedge Clk);
    chk("mid_data", {tx_en, txd, gnt1, gnt0}, {1'b1, 8'hF0, 2'b10});
    #1 rst_a_n = 1'b0;
    #1 chk("async_rst", {tx_en, tx_er, gnt1, gnt0, busy, rd1}, 0);
    @(negedge Clk);
    rst_a_n = 1'b1;
    @(negedge Clk);
    load_frame(1, 32'h31323300, 3);
    req1 = 1'b1;
    @(negedge Clk);
    req1 = 1'b0;
    check_frame(1, 3, -1);

    // Minimal preamble and gap, 1-byte frames back-to-back
    rst_a_n = 1'b0; rst_b_n = 1'b1; dut_sel = 1'b1;
    p_len = 1; i_len = 1;
    @(negedge Clk);
    chk("b_rst", obs_v, 14'd0);
    load_frame(0, 32'h5A000000, 1);
    req0 = 1'b1;
    @(negedge Clk);
    check_frame(0, 1, -1);
    check_frame(0, 1, -1);
    req0 = 1'b0;
    check_frame(0, 1, -1);
    chk("b_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
